div_iter_unit: RTL and testbench

- Iterative non-restoring integer divider for the EX stage; implements DIV, DIVU, REM and REMU.
- Sequences one row of controlled add/subtract cells over WIDTH cycles.
- Fed by the EX operand mux; the result is consumed by EX writeback through a valid/ready handshake.
- Asserts busy so the pipeline control can stall issue while a division is in progress.

---
 rtl/div_iter_unit_pkg.sv | 13 +
 rtl/div_iter_unit_if.sv | 17 +
 rtl/div_iter_unit_cas_row.sv | 18 +
 rtl/div_iter_unit.sv | 84 ++++++++
 tb/tb_div_iter_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/div_iter_unit_pkg.sv
// ex_div_pkg: shared op encodings, state constants and default width for the EX-stage divider.
package ex_div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_CALC = 2'd1;
    localparam state_t S_FIX  = 2'd2;
    localparam state_t S_DONE = 2'd3;
endpackage

// File: rtl/div_iter_unit_if.sv
// div_iter_unit_if: request/result handshake between the EX operand mux, the divider and writeback.
interface div_iter_unit_if import ex_div_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;
    modport master(output start, op, dividend, divisor, flush, out_ready,
                   input busy, out_valid, result, div_by_zero);
    modport slave(input start, op, dividend, divisor, flush, out_ready,
                  output busy, out_valid, result, div_by_zero);
endinterface

// File: rtl/div_iter_unit_cas_row.sv
// cas_row: one ripple-chained row of controlled add/subtract cells; add_sub=1 subtracts via inverted operand plus carry-in.
module cas_row #(parameter int N = 33) (
    input  logic         add_sub,
    input  logic [N-1:0] rem_shifted,
    input  logic [N-1:0] divisor_ext,
    output logic [N-1:0] sum
);
    logic [N-1:0] c;
    logic [N-1:0] b;
    assign c[0] = add_sub;
    for (genvar i = 0; i < N; i++) begin : g_cell
        assign b[i]   = divisor_ext[i] ^ add_sub;
        assign sum[i] = rem_shifted[i] ^ b[i] ^ c[i];
        if (i < N - 1) begin : g_carry
            assign c[i+1] = (rem_shifted[i] & b[i]) | (c[i] & (rem_shifted[i] ^ b[i]));
        end
    end
endmodule

// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative non-restoring DIV/DIVU/REM/REMU with sign fix-up and valid/ready result.
module div_iter_unit import ex_div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
    input logic clk,
    input logic rst,
    div_iter_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    state_t           state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo, dvs, result_q, abs_a, abs_b, rem_fix;
    logic [CNT_W-1:0] cnt;
    logic             op_rem, sign_q, sign_r, dbz;
    logic             signed_op, ovf, last;
    logic [WIDTH:0]   sum;
    assign signed_op = ~bus.op[0];
    assign abs_a = (signed_op & bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign abs_b = (signed_op & bus.divisor[WIDTH-1]) ? -bus.divisor : bus.divisor;
    assign ovf = signed_op & (bus.dividend == MIN) & (bus.divisor == '1);
    assign last = cnt == CNT_W'(WIDTH - 1);
    // Final remainder lies in [0, dvs), so the restore add only needs WIDTH bits.
    assign rem_fix = rem[WIDTH] ? rem[WIDTH-1:0] + dvs : rem[WIDTH-1:0];
    cas_row #(.N(WIDTH + 1)) u_row (
        .add_sub(~rem[WIDTH]),
        .rem_shifted({rem[WIDTH-1:0], quo[WIDTH-1]}),
        .divisor_ext({1'b0, dvs}),
        .sum(sum)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
            op_rem <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dbz <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start && !bus.flush) begin
                    op_rem <= bus.op[1];
                    sign_q <= signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    sign_r <= signed_op & bus.dividend[WIDTH-1];
                    dvs <= abs_b;
                    quo <= abs_a;
                    rem <= '0;
                    cnt <= '0;
                    dbz <= bus.divisor == '0;
                    if (bus.divisor == '0) begin
                        result_q <= bus.op[1] ? bus.dividend : '1;
                        state <= S_DONE;
                    end else if (ovf) begin
                        result_q <= bus.op[1] ? '0 : MIN;
                        state <= S_DONE;
                    end else begin
                        state <= S_CALC;
                    end
                end
                S_CALC: if (bus.flush) begin
                    state <= S_IDLE;
                end else begin
                    rem <= sum;
                    quo <= {quo[WIDTH-2:0], ~sum[WIDTH]};
                    cnt <= last ? cnt : cnt + 1'b1;
                    state <= last ? S_FIX : S_CALC;
                end
                S_FIX: if (bus.flush) begin
                    state <= S_IDLE;
                end else begin
                    result_q <= op_rem ? (sign_r ? -rem_fix : rem_fix) : (sign_q ? -quo : quo);
                    state <= S_DONE;
                end
                default: if (bus.flush || bus.out_ready) state <= S_IDLE;
            endcase
        end
    end
    assign bus.busy = state != S_IDLE;
    assign bus.out_valid = state == S_DONE;
    assign bus.result = result_q;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: randomized scoreboard bench for div_iter_unit against an arithmetic reference model.
module tb_div_iter_unit;
    import ex_div_pkg::*;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;
    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int           lat;
        int           acc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   seen = 0;
    exp_t sb_q[$];
    exp_t e;
    div_iter_unit_if #(.WIDTH(W)) bus ();
    div_iter_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
        end
    endtask
    // Reference: plain integer division semantics, RISC-V style corner cases.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   r;
        longint sa, sb, q, m;
        r.dbz = (b == 0);
        r.lat = 1;
        r.acc = 0;
        if (b == 0) begin
            r.res = op[1] ? a : '1;
        end else if (op[0] == 1'b0 && a == MIN && b == '1) begin
            r.res = op[1] ? '0 : MIN;
        end else begin
            r.lat = W + 2;
            if (op[0] == 1'b0) begin
                sa = $signed(a);
                sb = $signed(b);
            end else begin
                sa = a;
                sb = b;
            end
            q = sa / sb;
            m = sa % sb;
            r.res = op[1] ? m[W-1:0] : q[W-1:0];
        end
        return r;
    endfunction
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", bus.out_valid, 0);
            end else begin
                if (!seen) begin
                    seen = 1;
                    check("latency", cyc - sb_q[0].acc + 1, sb_q[0].lat);
                end
                if (bus.out_ready) begin
                    e = sb_q.pop_front();
                    check("result", bus.result, e.res);
                    check("div_by_zero", bus.div_by_zero, e.dbz);
                    seen = 0;
                end
            end
        end
    end
    task automatic wait_idle(input int lim);
        int n = 0;
        while (bus.busy && n < lim) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= lim) check("idle_timeout", bus.busy, 0);
    endtask
    task automatic accept(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle(200);
        bus.op = op;
        bus.dividend = a;
        bus.divisor = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        exp_t x;
        int   n = 0;
        x = model(op, a, b);
        bus.out_ready = (hold == 0);
        accept(op, a, b);
        x.acc = cyc;
        sb_q.push_back(x);
        if (hold > 0) begin
            while (!bus.out_valid && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("valid_seen", bus.out_valid, 1);
            for (int k = 0; k < hold; k++) begin
                bus.start = k[0];
                bus.dividend = $urandom;
                bus.divisor = $urandom;
                @(posedge clk);
                #1;
                check("hold_result", bus.result, x.res);
                check("hold_busy", bus.busy, 1);
            end
            bus.start = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("busy_after_accept", bus.busy, 0);
        end
        wait_idle(100);
    endtask
    function automatic logic [W-1:0] pick(input int mode);
        case ($urandom_range(0, 7))
            0: return mode == 0 ? MIN : '0;
            1: return '1;
            2: return W'($urandom_range(0, 20));
            3: return -W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction
    initial begin
        bus.start = 1'b0;
        bus.op = DIV_OP_DIV;
        bus.dividend = '0;
        bus.divisor = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_no_start", bus.busy, 0);
        do_op(DIV_OP_DIVU, 100, 7, 0);
        do_op(DIV_OP_REMU, 100, 7, 0);
        do_op(DIV_OP_DIV, 32'hFFFF_FF9C, 7, 0);
        do_op(DIV_OP_REM, 32'hFFFF_FF9C, 7, 0);
        do_op(DIV_OP_REM, 100, 32'hFFFF_FFF9, 0);
        do_op(DIV_OP_DIV, MIN, 32'hFFFF_FFFF, 0);
        do_op(DIV_OP_REM, MIN, 32'hFFFF_FFFF, 0);
        do_op(DIV_OP_DIVU, 5, 0, 0);
        do_op(DIV_OP_REM, 5, 0, 0);
        do_op(DIV_OP_DIVU, 100, 7, 10);
        // Flush in CALC: no result may ever appear for this request.
        accept(DIV_OP_DIVU, 1000, 3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        check("flush_valid", bus.out_valid, 0);
        repeat (40) @(posedge clk);
        #1;
        accept(DIV_OP_DIV, 32'h1234_5678, 9);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_result", bus.result, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("after_rst_idle", bus.busy, 0);
        do_op(DIV_OP_DIVU, 9, 3, 0);
        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(0, 3)), pick(0), pick(1), $urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 3));
        end
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
